// File: rtl/map_pkg.sv
// Shared tile codes, map geometry defaults, FSM states and row-word slicing for the map RAM writer.
package map_pkg;

   localparam logic [3:0] TILE_EMPTY  = 4'h0;
   localparam logic [3:0] TILE_WALL   = 4'h1;
   localparam logic [3:0] TILE_PILL   = 4'h2;
   localparam logic [3:0] TILE_PACMAN = 4'h3;
   localparam logic [3:0] TILE_GHOST  = 4'h4;

   localparam int MAP_COLS = 40;
   localparam int MAP_ROWS = 30;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REJECT,
      ST_CHK_RD,
      ST_CHK_WAIT,
      ST_CUR_RD,
      ST_CUR_WAIT,
      ST_CUR_WR,
      ST_NXT_RD,
      ST_NXT_WAIT,
      ST_NXT_WR,
      ST_DONE
   } map_state_t;

   // Column 0 sits at the MSB end of the row word.
   function automatic int tile_lsb(input int col, input int cols, input int tile_w);
      return (cols - 1 - col) * tile_w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant of the lowest requester at or after the pointer;
// the pointer moves past the winner only when advance is asserted.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] index,
   output logic             any
);

   logic [IDX_W-1:0] ptr_q;

   always_comb begin
      int c;
      c     = 0;
      any   = 1'b0;
      index = '0;
      grant = '0;
      for (int i = 0; i < N; i++) begin
         c = (int'(ptr_q) + i) % N;
         if (!any && req[c]) begin
            any   = 1'b1;
            index = IDX_W'(c);
         end
      end
      if (any) grant[index] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (advance && any) begin
         ptr_q <= (index == IDX_W'(N - 1)) ? '0 : index + 1'b1;
      end
   end

endmodule

// File: rtl/map_sprite_writer.sv
// Arbitrated read-modify-write sprite mover on map_RAM port B: done 9 cycles after grant, 3 if walled, 2 if rejected.
// Requests are levels held until done; MAP_PILL_COUNT_EN adds a saturating pill counter for channel 0.
module map_sprite_writer
   import map_pkg::*;
#(
   parameter int                      N_SPR        = 3,
   parameter int                      COLS         = MAP_COLS,
   parameter int                      ROWS         = MAP_ROWS,
   parameter int                      TILE_W       = 4,
   parameter int                      X_W          = 6,
   parameter int                      Y_W          = 5,
   parameter logic [N_SPR*TILE_W-1:0] SPR_CODES    = {4'h4, 4'h4, 4'h3},
   parameter logic [N_SPR-1:0]        RESTORE_MASK = 3'b110
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic [N_SPR-1:0]         req,
   input  logic [N_SPR*X_W-1:0]     curr_x,
   input  logic [N_SPR*Y_W-1:0]     curr_y,
   input  logic [N_SPR*X_W-1:0]     next_x,
   input  logic [N_SPR*Y_W-1:0]     next_y,
   output logic [N_SPR-1:0]         done,
   output logic                     blocked,
   output logic [TILE_W-1:0]        hit_code,
   output logic [Y_W-1:0]           ram_addr,
   output logic [COLS*TILE_W-1:0]   ram_wdata,
   output logic                     ram_wren,
   input  logic [COLS*TILE_W-1:0]   ram_rdata,
   output logic [15:0]              pill_count
);

   localparam int IDX_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;
   localparam int ROW_W = COLS * TILE_W;
   localparam logic [TILE_W-1:0] T_EMPTY = TILE_W'(TILE_EMPTY);
   localparam logic [TILE_W-1:0] T_WALL  = TILE_W'(TILE_WALL);

   map_state_t         state_q, state_d;
   logic [N_SPR-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_index;
   logic               arb_any;

   logic [N_SPR-1:0]   gnt_q;
   logic [IDX_W-1:0]   g_q;
   logic [X_W-1:0]     cx_q, nx_q, sel_cx, sel_nx;
   logic [Y_W-1:0]     cy_q, ny_q, sel_cy, sel_ny;
   logic               reject;
   logic               blocked_q;
   logic [TILE_W-1:0]  hit_q;
   logic [ROW_W-1:0]   row_q;
   logic [TILE_W-1:0]  under [N_SPR];
   logic [TILE_W-1:0]  chk_tile, restore_code, spr_code;
   logic               hit_is_spr;

   rr_arbiter #(.N(N_SPR), .IDX_W(IDX_W)) u_arb (
      .clk     (CLOCK_50),
      .rst     (reset),
      .req     (req),
      .advance (state_q == ST_IDLE),
      .grant   (arb_grant),
      .index   (arb_index),
      .any     (arb_any)
   );

   assign sel_cx = curr_x[int'(arb_index)*X_W +: X_W];
   assign sel_cy = curr_y[int'(arb_index)*Y_W +: Y_W];
   assign sel_nx = next_x[int'(arb_index)*X_W +: X_W];
   assign sel_ny = next_y[int'(arb_index)*Y_W +: Y_W];

   // Off-map targets and zero-length moves never touch the RAM.
   assign reject = (int'(sel_nx) >= COLS) || (int'(sel_ny) >= ROWS) ||
                   ((sel_nx == sel_cx) && (sel_ny == sel_cy));

   assign chk_tile     = ram_rdata[tile_lsb(int'(nx_q), COLS, TILE_W) +: TILE_W];
   assign restore_code = RESTORE_MASK[g_q] ? under[g_q] : T_EMPTY;
   assign spr_code     = SPR_CODES[int'(g_q)*TILE_W +: TILE_W];

   always_comb begin
      hit_is_spr = 1'b0;
      for (int i = 0; i < N_SPR; i++) begin
         if (hit_q == SPR_CODES[i*TILE_W +: TILE_W]) hit_is_spr = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (arb_any) state_d = reject ? ST_REJECT : ST_CHK_RD;
         ST_REJECT:   state_d = ST_DONE;
         ST_CHK_RD:   state_d = ST_CHK_WAIT;
         ST_CHK_WAIT: state_d = (chk_tile == T_WALL) ? ST_DONE : ST_CUR_RD;
         ST_CUR_RD:   state_d = ST_CUR_WAIT;
         ST_CUR_WAIT: state_d = ST_CUR_WR;
         ST_CUR_WR:   state_d = ST_NXT_RD;
         ST_NXT_RD:   state_d = ST_NXT_WAIT;
         ST_NXT_WAIT: state_d = ST_NXT_WR;
         ST_NXT_WR:   state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      done      = '0;
      blocked   = 1'b0;
      hit_code  = hit_q;
      ram_wren  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state_q)
         ST_CHK_RD, ST_CHK_WAIT, ST_NXT_RD, ST_NXT_WAIT: ram_addr = ny_q;
         ST_CUR_RD, ST_CUR_WAIT: ram_addr = cy_q;
         ST_CUR_WR: begin
            ram_addr  = cy_q;
            ram_wren  = 1'b1;
            ram_wdata = row_q;
            ram_wdata[tile_lsb(int'(cx_q), COLS, TILE_W) +: TILE_W] = restore_code;
         end
         ST_NXT_WR: begin
            ram_addr  = ny_q;
            ram_wren  = 1'b1;
            ram_wdata = row_q;
            ram_wdata[tile_lsb(int'(nx_q), COLS, TILE_W) +: TILE_W] = spr_code;
         end
         ST_DONE: begin
            done    = gnt_q;
            blocked = blocked_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         gnt_q     <= '0;
         g_q       <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         nx_q      <= '0;
         ny_q      <= '0;
         blocked_q <= 1'b0;
         hit_q     <= T_EMPTY;
         row_q     <= '0;
         for (int i = 0; i < N_SPR; i++) under[i] <= T_EMPTY;
      end else begin
         case (state_q)
            ST_IDLE: if (arb_any) begin
               gnt_q     <= arb_grant;
               g_q       <= arb_index;
               cx_q      <= sel_cx;
               cy_q      <= sel_cy;
               nx_q      <= sel_nx;
               ny_q      <= sel_ny;
               blocked_q <= reject;
               hit_q     <= T_EMPTY;
            end
            ST_CHK_WAIT: begin
               hit_q <= chk_tile;
               if (chk_tile == T_WALL) blocked_q <= 1'b1;
            end
            ST_CUR_WAIT, ST_NXT_WAIT: row_q <= ram_rdata;
            // Standing on another sprite must not leave a stale sprite behind later.
            ST_NXT_WR: under[g_q] <= hit_is_spr ? T_EMPTY : hit_q;
            default: ;
         endcase
      end
   end

`ifdef MAP_PILL_COUNT_EN
   localparam logic [TILE_W-1:0] T_PILL = TILE_W'(TILE_PILL);
   logic [15:0] pill_q;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pill_q <= '0;
      end else if ((state_q == ST_NXT_WR) && (g_q == '0) && (hit_q == T_PILL) &&
                   (pill_q != 16'hFFFF)) begin
         pill_q <= pill_q + 16'd1;
      end
   end

   assign pill_count = pill_q;
`else
   assign pill_count = 16'h0;
`endif

endmodule

// File: tb/tb_map_sprite_writer.sv
// Directed bench for map_sprite_writer with a 1-cycle-latency behavioural map RAM.
module tb_map_sprite_writer;

   logic         CLOCK_50;
   logic         reset;
   logic [2:0]   req;
   logic [17:0]  curr_x, next_x;
   logic [14:0]  curr_y, next_y;
   logic [2:0]   done;
   logic         blocked;
   logic [3:0]   hit_code;
   logic [4:0]   ram_addr;
   logic [159:0] ram_wdata, ram_rdata;
   logic         ram_wren;
   logic [15:0]  pill_count;

   logic [159:0] mem [32];
   logic         poke, clr;
   int           poke_row, poke_col;
   logic [3:0]   poke_val;
   int           wr_rows[$];
   logic [2:0]   order[$];

   int total = 0;
   int bad   = 0;

`ifdef MAP_PILL_COUNT_EN
   localparam int PILL_EXP = 1;
`else
   localparam int PILL_EXP = 0;
`endif

   map_sprite_writer dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .req        (req),
      .curr_x     (curr_x),
      .curr_y     (curr_y),
      .next_x     (next_x),
      .next_y     (next_y),
      .done       (done),
      .blocked    (blocked),
      .hit_code   (hit_code),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_wren   (ram_wren),
      .ram_rdata  (ram_rdata),
      .pill_count (pill_count)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (clr) begin
         for (int r = 0; r < 32; r++) mem[r] <= '0;
      end else if (poke) begin
         mem[poke_row][159-4*poke_col -: 4] <= poke_val;
      end else if (ram_wren) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   always @(negedge CLOCK_50) begin
      if (ram_wren) wr_rows.push_back(int'(ram_addr));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] tile_at(input int row, input int col);
      logic [159:0] w;
      w = mem[row];
      return w[159-4*col -: 4];
   endfunction

   task automatic put_tile(input int row, input int col, input logic [3:0] v);
      poke_row = row; poke_col = col; poke_val = v; poke = 1'b1;
      @(posedge CLOCK_50); #1;
      poke = 1'b0;
   endtask

   task automatic set_coords(input int ch, input int cx, input int cy, input int nx, input int ny);
      curr_x[ch*6 +: 6] = 6'(cx);
      curr_y[ch*5 +: 5] = 5'(cy);
      next_x[ch*6 +: 6] = 6'(nx);
      next_y[ch*5 +: 5] = 5'(ny);
   endtask

   // Cycle 0 is the IDLE cycle in which the request is first visible.
   task automatic do_move(input int ch, input int cx, input int cy, input int nx, input int ny,
                          output int cyc, output logic [2:0] dv, output logic blk,
                          output logic [3:0] hit);
      @(posedge CLOCK_50); #1;
      wr_rows.delete();
      set_coords(ch, cx, cy, nx, ny);
      req[ch] = 1'b1;
      cyc = -1; dv = '0; blk = 1'b0; hit = '0;
      for (int n = 0; n < 40 && cyc < 0; n++) begin
         @(negedge CLOCK_50);
         if (done != 0) begin
            cyc = n; dv = done; blk = blocked; hit = hit_code;
         end
      end
      req[ch] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc;
      logic [2:0] dv;
      logic       blk;
      logic [3:0] hit;

      reset = 1'b1; req = '0; poke = 1'b0; clr = 1'b1;
      poke_row = 0; poke_col = 0; poke_val = '0;
      curr_x = '0; curr_y = '0; next_x = '0; next_y = '0;
      #5;
      check("rst_done",    32'(done),       0);
      check("rst_blocked", 32'(blocked),    0);
      check("rst_hit",     32'(hit_code),   0);
      check("rst_wren",    32'(ram_wren),   0);
      check("rst_addr",    32'(ram_addr),   0);
      check("rst_wdata",   32'(ram_wdata),  0);
      check("rst_pill",    32'(pill_count), 0);
      @(posedge CLOCK_50); #1;
      clr = 1'b0;
      put_tile(5, 3, 4'h3);
      put_tile(5, 4, 4'h2);
      put_tile(10, 9, 4'h4);
      put_tile(10, 10, 4'h2);
      put_tile(20, 6, 4'h4);
      put_tile(20, 7, 4'h1);
      reset = 1'b0;

      do_move(0, 3, 5, 4, 5, cyc, dv, blk, hit);
      check("t1_cycle",   32'(cyc), 9);
      check("t1_done",    32'(dv), 32'h1);
      check("t1_blocked", 32'(blk), 0);
      check("t1_hit",     32'(hit), 2);
      check("t1_nwr",     32'(wr_rows.size()), 2);
      if (wr_rows.size() == 2) begin
         check("t1_row0", 32'(wr_rows[0]), 5);
         check("t1_row1", 32'(wr_rows[1]), 5);
      end
      check("t1_old",  32'(tile_at(5, 3)), 0);
      check("t1_new",  32'(tile_at(5, 4)), 3);
      check("t1_pill", 32'(pill_count), PILL_EXP);

      do_move(1, 9, 10, 10, 10, cyc, dv, blk, hit);
      check("t2a_cycle", 32'(cyc), 9);
      check("t2a_done",  32'(dv), 32'h2);
      check("t2a_hit",   32'(hit), 2);
      check("t2a_old",   32'(tile_at(10, 9)), 0);
      check("t2a_new",   32'(tile_at(10, 10)), 4);
      do_move(1, 10, 10, 11, 10, cyc, dv, blk, hit);
      check("t2b_hit",     32'(hit), 0);
      check("t2b_restore", 32'(tile_at(10, 10)), 2);
      check("t2b_new",     32'(tile_at(10, 11)), 4);
      check("t2b_pill",    32'(pill_count), PILL_EXP);

      do_move(2, 6, 20, 7, 20, cyc, dv, blk, hit);
      check("wall_cycle",   32'(cyc), 3);
      check("wall_done",    32'(dv), 32'h4);
      check("wall_blocked", 32'(blk), 1);
      check("wall_hit",     32'(hit), 1);
      check("wall_nwr",     32'(wr_rows.size()), 0);
      check("wall_keep",    32'(tile_at(20, 6)), 4);

      @(posedge CLOCK_50); #1;
      wr_rows.delete();
      order.delete();
      set_coords(0, 4, 5, 5, 5);
      set_coords(1, 11, 10, 12, 10);
      set_coords(2, 6, 20, 6, 21);
      req = 3'b111;
      for (int n = 0; n < 100 && order.size() < 4; n++) begin
         @(negedge CLOCK_50);
         if (done != 0) order.push_back(done);
      end
      req = '0;
      check("rr_count", 32'(order.size()), 4);
      if (order.size() == 4) begin
         check("rr_g0", 32'(order[0]), 32'h1);
         check("rr_g1", 32'(order[1]), 32'h2);
         check("rr_g2", 32'(order[2]), 32'h4);
         check("rr_g3", 32'(order[3]), 32'h1);
      end
      @(posedge CLOCK_50); #1;
      check("rr_nwr",   32'(wr_rows.size()), 8);
      check("rr_p_new", 32'(tile_at(5, 5)), 3);
      check("rr_p_old", 32'(tile_at(5, 4)), 0);
      check("rr_g1new", 32'(tile_at(10, 12)), 4);
      check("rr_g1old", 32'(tile_at(10, 11)), 0);
      check("rr_g2new", 32'(tile_at(21, 6)), 4);
      check("rr_g2old", 32'(tile_at(20, 6)), 0);

      do_move(0, 5, 5, 40, 5, cyc, dv, blk, hit);
      check("rej_x_cycle",   32'(cyc), 2);
      check("rej_x_blocked", 32'(blk), 1);
      check("rej_x_hit",     32'(hit), 0);
      check("rej_x_nwr",     32'(wr_rows.size()), 0);
      do_move(1, 12, 10, 12, 10, cyc, dv, blk, hit);
      check("rej_same_cycle",   32'(cyc), 2);
      check("rej_same_done",    32'(dv), 32'h2);
      check("rej_same_blocked", 32'(blk), 1);
      check("rej_same_nwr",     32'(wr_rows.size()), 0);

      @(posedge CLOCK_50); #1;
      set_coords(1, 12, 10, 13, 10);
      req[1] = 1'b1;
      cyc = -1;
      for (int n = 0; n < 20 && cyc < 0; n++) begin
         @(negedge CLOCK_50);
         if (ram_wren) cyc = n;
      end
      check("mid_wr_cycle", 32'(cyc), 5);
      #5 reset = 1'b1;
      #1;
      check("mid_wren",  32'(ram_wren),  0);
      check("mid_done",  32'(done),      0);
      check("mid_addr",  32'(ram_addr),  0);
      check("mid_wdata", 32'(ram_wdata), 0);
      check("mid_hit",   32'(hit_code),  0);
      req = '0;
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
      check("mid_old_kept", 32'(tile_at(10, 12)), 4);
      check("mid_new_none", 32'(tile_at(10, 13)), 0);

      @(posedge CLOCK_50); #1;
      set_coords(0, 5, 5, 6, 5);
      set_coords(2, 6, 21, 7, 21);
      req = 3'b101;
      dv = '0;
      for (int n = 0; n < 40 && dv == 0; n++) begin
         @(negedge CLOCK_50);
         if (done != 0) dv = done;
      end
      req = '0;
      check("post_rst_grant", 32'(dv), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
